// File: rtl/gf163_pkg.sv
// rtl/gf163_pkg.sv - shared constants, types and FSM encoding for GF(2^163) reduction
package gf163_pkg;

  localparam int M      = 163;
  localparam int PROD_W = 2 * M - 1;

  // f(x) = x^163 + x^7 + x^6 + x^3 + 1 : low-order taps as a bit set
  localparam logic [7:0] TAP_MASK = 8'b1100_1001;

  typedef logic [M-1:0]      gf163_t;
  typedef logic [PROD_W-1:0] gf163_prod_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nfold_of(input int digit);
    return (M - 1 + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/gf163_fold_window.sv
// rtl/gf163_fold_window.sv - XOR mask that folds one window of high coefficients
module gf163_fold_window
  import gf163_pkg::*;
#(
  parameter int DIGIT = 32
) (
  input  logic [DIGIT-1:0]  i_slice,
  input  logic [8:0]        i_base,
  output logic [PROD_W-1:0] o_mask
);

  gf163_prod_t w_win;

  // The window itself is XORed back in to clear it; each tap lands at k-163+t.
  always_comb begin
    w_win  = gf163_prod_t'(i_slice) << i_base;
    o_mask = w_win;
    for (int t = 0; t < 8; t++) begin
      if (TAP_MASK[t]) begin
        o_mask = o_mask ^ (w_win >> (M - t));
      end
    end
  end

endmodule

// File: rtl/gf163_reduce_seq.sv
// rtl/gf163_reduce_seq.sv - digit-serial reduction of a 325-bit product modulo f(x)
module gf163_reduce_seq
  import gf163_pkg::*;
#(
  parameter int DIGIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_z,
  output logic              busy
);

  localparam int NFOLD  = nfold_of(DIGIT);
  localparam int STEP_W = $clog2(NFOLD);

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  gf163_prod_t         r_w;

  logic [8:0]          w_base;
  logic [DIGIT-1:0]    w_raw;
  logic [DIGIT-1:0]    w_slice;
  gf163_prod_t         w_mask;
  gf163_prod_t         w_next;

  // The last window may reach below degree 163; those bits are already reduced.
  always_comb begin
    w_base = 9'(PROD_W - DIGIT - int'(r_step) * DIGIT);
    w_raw  = r_w[w_base +: DIGIT];
    for (int j = 0; j < DIGIT; j++) begin
      w_slice[j] = w_raw[j] & ((int'(w_base) + j) >= M);
    end
  end

  gf163_fold_window #(
    .DIGIT (DIGIT)
  ) u_fold (
    .i_slice (w_slice),
    .i_base  (w_base),
    .o_mask  (w_mask)
  );

  assign w_next = r_w ^ w_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_w       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_z     <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_w      <= in_c;
            r_step   <= '0;
            r_state  <= ST_FOLD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_FOLD: begin
          r_w <= w_next;
          if (r_step == STEP_W'(NFOLD - 1)) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            out_z     <= w_next[M-1:0];
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
